// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, ALUOp codes,
// datapath mux encodings, FSM state encodings and the decoded control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_R    = 4'b1111;
  localparam logic [3:0] ALU_ORI  = 4'b1010;
  localparam logic [3:0] ALU_ANDI = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b0010;
  localparam logic [3:0] ALU_BEQ  = 4'b0100;
  localparam logic [3:0] ALU_BNE  = 4'b0111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCondEq;
    logic       pcWriteCondNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       jal;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [3:0] aluOp;
    logic       instrDone;
  } ctrl_word_t;

  function automatic logic isKnownOp(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ORI, OP_ANDI, OP_LUI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J, OP_JAL: isKnownOp = 1'b1;
      default:                      isKnownOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational decode of (state, opcode) into the raw control word.
// Handshake gating and reset masking are applied by the top level.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  output ctrl_word_t ctrl_o
);

  // Every state starts from an all-zero word and sets only what it needs.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.irWrite = 1'b1;
        ctrl_o.pcWrite = 1'b1;
        ctrl_o.aluSrcB = SRCB_FOUR;
        ctrl_o.aluOp   = ALU_ADD;
      end
      S_DECODE: begin
        ctrl_o.aluSrcB   = SRCB_IMM_SL2;
        ctrl_o.aluOp     = ALU_ADD;
`ifndef MULTICYCLE_ILLEGAL_OP_TRAP_EN
        ctrl_o.instrDone = !isKnownOp(op_i);
`endif
      end
      S_R_EXEC: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_RT;
        ctrl_o.aluOp   = ALU_R;
      end
      S_R_WB: begin
        ctrl_o.regDst    = 1'b1;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        case (op_i)
          OP_ORI:  ctrl_o.aluOp = ALU_ORI;
          OP_ANDI: ctrl_o.aluOp = ALU_ANDI;
          OP_LUI:  ctrl_o.aluOp = ALU_LUI;
          default: ctrl_o.aluOp = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.iorD    = 1'b1;
        ctrl_o.memRead = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.memtoReg  = 1'b1;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.iorD      = 1'b1;
        ctrl_o.memWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.aluSrcA       = 1'b1;
        ctrl_o.aluSrcB       = SRCB_RT;
        ctrl_o.pcSource      = PCSRC_ALUOUT;
        ctrl_o.aluOp         = (op_i == OP_BNE) ? ALU_BNE : ALU_BEQ;
        ctrl_o.pcWriteCondNe = (op_i == OP_BNE);
        ctrl_o.pcWriteCondEq = (op_i != OP_BNE);
        ctrl_o.instrDone     = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcWrite   = 1'b1;
        ctrl_o.pcSource  = PCSRC_JUMP;
        ctrl_o.instrDone = 1'b1;
      end
      S_JAL: begin
        ctrl_o.pcWrite   = 1'b1;
        ctrl_o.pcSource  = PCSRC_JUMP;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.jal       = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with optional variable-latency memory handshake.
// Define MULTICYCLE_ILLEGAL_OP_TRAP_EN to trap unknown opcodes instead of NOPing them.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W       = 4,
  parameter int MEM_HANDSHAKE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCondEQ,
  output logic               PCWriteCondNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               Jal,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state_dbg
);

  state_t     state_q, state_d;
  ctrl_word_t ctrl;
  logic       memDone;
  logic       stall;

  multicycle_ctrl_decode u_decode (
    .state_i (state_q),
    .op_i    (OP),
    .ctrl_o  (ctrl)
  );

  assign memDone = (MEM_HANDSHAKE == 0) || mem_ready;
  assign stall   = (state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) && !memDone;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (memDone) state_d = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_RTYPE:                         state_d = S_R_EXEC;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = S_I_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          OP_JAL:                           state_d = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_OP_TRAP_EN
          default:                          state_d = S_TRAP;
`else
          default:                          state_d = S_FETCH;
`endif
        endcase
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_ADDR:  state_d = (OP == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (memDone) state_d = S_MEM_WB;
      S_MEM_WRITE: if (memDone) state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_OP_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // Strobes are masked during reset; PC/IR loads and completion also wait
  // for the memory, while MemRead/MemWrite/IorD are held through a stall.
  assign PCWrite       = ctrl.pcWrite   && !reset && !stall;
  assign IRWrite       = ctrl.irWrite   && !reset && !stall;
  assign instr_done    = ctrl.instrDone && !reset && !stall;
  assign PCWriteCondEQ = ctrl.pcWriteCondEq && !reset;
  assign PCWriteCondNE = ctrl.pcWriteCondNe && !reset;
  assign RegWrite      = ctrl.regWrite && !reset;
  assign MemWrite      = ctrl.memWrite && !reset;
  assign MemRead       = ctrl.memRead;
  assign IorD          = ctrl.iorD;
  assign MemtoReg      = ctrl.memtoReg;
  assign RegDst        = ctrl.regDst;
  assign Jal           = ctrl.jal;
  assign ALUSrcA       = ctrl.aluSrcA;
  assign ALUSrcB       = ctrl.aluSrcB;
  assign PCSource      = ctrl.pcSource;
  assign ALUOp         = ALUOP_W'(ctrl.aluOp);
  assign state_dbg     = state_q;

`ifdef MULTICYCLE_ILLEGAL_OP_TRAP_EN
  assign illegal_op = (state_q == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation MIPS control unit: a multi-cycle FSM that sequences FETCH/DECODE/EXECUTE/MEM/WB for the existing instruction subset.
- Supported opcodes: R-type, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE, J, JAL.
- Generalised ALUOp width and an optional variable-latency memory handshake.
- Sits between the IR opcode field and the shared-ALU / single-memory multicycle datapath.

Parameters:
- ALUOP_W, 4: ALUOp output width. Must be ≥4; codes are zero-extended.
- MEM_HANDSHAKE, 0: 0 = memory completes in 1 cycle and mem_ready is ignored. 1 = memory states stall until mem_ready=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- OP  in  6  opcode from IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory access complete (used only when MEM_HANDSHAKE=1).
- PCWrite  out  1  unconditional PC load.
- PCWriteCondEQ  out  1  PC load if ALU zero.
- PCWriteCondNE  out  1  PC load if not zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read.
- MemWrite  out  1  memory write.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  register write data = MDR.
- RegDst  out  1  destination = rd.
- RegWrite  out  1  register file write.
- Jal  out  1  destination forced to $31, data = PC.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  out  ALUOP_W  ALU control code.
- instr_done  out  1  one-cycle pulse in an instruction's final cycle.
- illegal_op  out  1  trap flag (see Optional Feature).
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset:
  - state = FETCH asynchronously.
  - PCWrite, IRWrite, RegWrite, MemWrite, PCWriteCond* and instr_done are forced 0 while reset=1.
  - illegal_op = 0.
  - Other outputs show the FETCH decode.
  - Reset mid-instruction abandons it; no partial write is ever issued after reset deassertion.
- Output timing: outputs are combinational from state (Moore), except write enables in memory states, which are gated by the handshake.
- ALUOp codes:
  - ADD = 1000 (FETCH, DECODE, LW, SW, ADDI)
  - R = 1111, ORI = 1010, ANDI = 1100, LUI = 0010
  - BEQ = 0100, BNE = 0111
  - Other states = 0.
- FETCH:
  - Asserts MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite and PCWrite assert only in the completing cycle: always when MEM_HANDSHAKE=0, otherwise when mem_ready=1.
  - Stays in FETCH until complete, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Next state by OP:
  - R → R_EXEC
  - ADDI/ORI/ANDI/LUI → I_EXEC
  - LW/SW → MEM_ADDR
  - BEQ/BNE → BRANCH
  - J → JUMP
  - JAL → JAL
  - anything else → see Optional Feature
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=R. Next: R_WB.
- R_WB: RegDst=1, RegWrite=1, instr_done. Next: FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode. Next: I_WB.
- I_WB: RegDst=0, RegWrite=1, instr_done. Next: FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Next: LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ: IorD=1, MemRead=1; holds until complete. Next: MEM_WB.
- MEM_WB: MemtoReg=1, RegWrite=1, instr_done. Next: FETCH.
- MEM_WRITE: IorD=1, MemWrite=1 held until complete; instr_done in the completing cycle. Next: FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=BEQ/BNE, PCSource=01.
  - PCWriteCondEQ (BEQ) or PCWriteCondNE (BNE); instr_done. Next: FETCH.
- JUMP: PCWrite, PCSource=10, instr_done. Next: FETCH.
- JAL: PCWrite, PCSource=10, RegWrite, Jal=1, instr_done. Writes the already-incremented PC to $31. Next: FETCH.
- Latency with MEM_HANDSHAKE=0: R/I/SW = 4 cycles, LW = 5, BEQ/BNE/J/JAL = 3. Each mem_ready=0 cycle adds one cycle.
- Hold rules (MEM_HANDSHAKE=1):
  - In memory states with mem_ready=0, MemRead/MemWrite/IorD stay stable and write enables stay 0.
  - mem_ready outside memory states is ignored.
- state_dbg encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - R_EXEC = 6, R_WB = 7, I_EXEC = 8, I_WB = 9
  - BRANCH = 10, JUMP = 11, JAL = 12, TRAP = 13
  - 14–15 unreachable; recover to FETCH.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unknown OP in DECODE goes to TRAP and sets illegal_op=1 (sticky).
  - TRAP asserts no enables and is left only by reset.
- Undefined:
  - An unknown OP in DECODE pulses instr_done and returns to FETCH (NOP).
  - TRAP is not built; illegal_op is tied 0.

Decomposition:
- Package mips_ctrl_pkg:
  - Opcode constants: 00, 08, 0d, 0c, 0f, 23, 2b, 04, 05, 02, 03.
  - ALUOp codes and the ALUSrcB/PCSource encodings.
  - State encodings.
- Sub-module multicycle_ctrl_decode: pure combinational state+OP → control-word decode. The top keeps the state register, next-state logic and handshake gating.

Test Plan:
- Reset asserted mid-MEM_WRITE with mem_ready=0 → state_dbg=0 immediately; MemWrite=0 throughout reset; first fetch follows deassertion.
- MEM_HANDSHAKE=0, OP=00 (R-type) → states 0,1,6,7; ALUOp=1111 in R_EXEC; RegDst=RegWrite=1 and instr_done in cycle 4.
- MEM_HANDSHAKE=1, OP=23 (LW), mem_ready low 2 cycles in FETCH and 3 in MEM_READ → IRWrite pulses once; RegWrite+MemtoReg after 10 cycles total; no early enables.
- OP=05 (BNE) → 3 cycles; PCWriteCondNE=1, ALUOp=0111, PCSource=01 in BRANCH. OP=03 (JAL) → PCWrite, RegWrite, Jal=1 in cycle 3.
- OP=3f with macro defined → state 13, illegal_op=1 stays set for 20 cycles, no enables. Without the macro → instr_done in DECODE, return to FETCH.
